// File: rtl/max_pool_unit.sv
// 2x2 stride-2 signed max-pooling stage over a raster-order valid/ready stream.
// Keeps one row of partial maxima and emits each pooled value with its write address.
module max_pool_unit #(
  parameter int IN_WIDTH  = 6,
  parameter int IN_HEIGHT = 6,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  input  logic              out_ready,
  output logic              frame_done
);

  localparam int COL_W = (IN_WIDTH > 2) ? $clog2(IN_WIDTH) : 2;
  localparam int ROW_W = (IN_HEIGHT > 2) ? $clog2(IN_HEIGHT) : 1;
  localparam int K_W   = COL_W - 1;
  localparam int PW    = IN_WIDTH / 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e            state_q;
  logic [ROW_W-1:0]  row_q;
  logic [COL_W-1:0]  col_q;
  logic [DATA_W-1:0] tmp_q;
  logic [DATA_W-1:0] pmax_q [PW];
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic              frame_done_q;

  logic              in_ready_s;
  logic              in_xfer_s;
  logic              out_xfer_s;
  logic              last_col_s;
  logic              last_row_s;
  logic              pmax_we_s;
  logic [K_W-1:0]    k_s;
  logic [COL_W-1:0]  col_d;
  logic [ROW_W-1:0]  row_d;
  logic [DATA_W-1:0] lo_max_s;
  logic [DATA_W-1:0] hi_max_s;

  function automatic logic [DATA_W-1:0] smax(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    if ($signed(a) > $signed(b)) begin
      r = a;
    end else begin
      r = b;
    end
    return r;
  endfunction

  // Handshake qualifiers, raster counters' next values and the two max candidates.
  always_comb begin
    in_ready_s = (state_q == S_RUN) && (!out_valid_q || out_ready);
    in_xfer_s  = in_valid && in_ready_s;
    out_xfer_s = out_valid_q && out_ready;
    k_s        = col_q[COL_W-1:1];
    last_col_s = (col_q == COL_W'(IN_WIDTH - 1));
    last_row_s = (row_q == ROW_W'(IN_HEIGHT - 1));
    if (last_col_s) begin
      col_d = {COL_W{1'b0}};
      row_d = last_row_s ? {ROW_W{1'b0}} : row_q + ROW_W'(1);
    end else begin
      col_d = col_q + COL_W'(1);
      row_d = row_q;
    end
    lo_max_s  = smax(tmp_q, in_data);
    hi_max_s  = smax(pmax_q[k_s], in_data);
    pmax_we_s = rst && in_xfer_s && !row_q[0] && col_q[0];
  end

  // Line buffer of horizontal pair maxima from the even row; never needs clearing.
  always_ff @(posedge clk) begin
    if (pmax_we_s) begin
      pmax_q[k_s] <= lo_max_s;
    end
  end

  // Frame control FSM and the registered output stage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      row_q        <= {ROW_W{1'b0}};
      col_q        <= {COL_W{1'b0}};
      tmp_q        <= {DATA_W{1'b0}};
      out_valid_q  <= 1'b0;
      out_data_q   <= {DATA_W{1'b0}};
      out_addr_q   <= {ADDR_W{1'b0}};
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      // A drained output may be replaced by a new one loaded below in the same cycle.
      if (out_xfer_s) begin
        out_valid_q <= 1'b0;
        out_addr_q  <= out_addr_q + ADDR_W'(1);
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_RUN;
            row_q      <= {ROW_W{1'b0}};
            col_q      <= {COL_W{1'b0}};
            out_addr_q <= {ADDR_W{1'b0}};
          end
        end
        S_RUN: begin
          if (in_xfer_s) begin
            col_q <= col_d;
            row_q <= row_d;
            case ({row_q[0], col_q[0]})
              2'b00:   tmp_q <= in_data;
              2'b10:   tmp_q <= hi_max_s;
              2'b11: begin
                out_data_q  <= lo_max_s;
                out_valid_q <= 1'b1;
              end
              default: tmp_q <= tmp_q;
            endcase
            if (last_row_s && last_col_s) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (out_xfer_s) begin
            state_q      <= S_DONE;
            frame_done_q <= 1'b1;
          end
        end
        S_DONE: begin
          state_q    <= S_IDLE;
          out_addr_q <= {ADDR_W{1'b0}};
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_addr   = out_addr_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_max_pool_unit.sv
// Randomized self-checking bench for max_pool_unit against a frame-level 2x2 max reference.
module tb_max_pool_unit;

  localparam int W  = 6;
  localparam int H  = 6;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int PW = W / 2;
  localparam int PH = H / 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_ready;
  logic          frame_done;

  always #5 clk = ~clk;

  max_pool_unit #(.IN_WIDTH(W), .IN_HEIGHT(H), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_addr(out_addr),
    .out_ready(out_ready), .frame_done(frame_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at t=%0t",
               tag, $signed(got), got, $signed(exp), exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] d;
    logic [31:0] a;
  } exp_t;

  logic [31:0] img [H][W];
  exp_t        exp_q[$];

  // Reference: every pooled value is the signed max of its 2x2 window.
  task automatic load_model();
    for (int pr = 0; pr < PH; pr++) begin
      for (int pc = 0; pc < PW; pc++) begin
        exp_t e;
        e.d = img[2*pr][2*pc];
        for (int dr = 0; dr < 2; dr++)
          for (int dc = 0; dc < 2; dc++)
            if ($signed(img[2*pr+dr][2*pc+dc]) > $signed(e.d)) e.d = img[2*pr+dr][2*pc+dc];
        e.a = pr * PW + pc;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = r * W + c;
  endtask

  task automatic fill_signed();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = -5;
    img[0][1] = -1;
    img[5][5] = -7;
  endtask

  task automatic fill_random();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = $urandom;
  endtask

  // Output monitor: scoreboard, hold-under-backpressure and frame_done timing.
  int          cyc          = 0;
  int          last_out_cyc = -10;
  int          last_out_adr = -1;
  int          done_cnt     = 0;
  logic        mon_ok       = 1'b0;
  logic        pv           = 1'b0;
  logic        pr_q         = 1'b0;
  logic [31:0] pd           = '0;
  logic [AW-1:0] pa         = '0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (mon_ok && pv && !pr_q) begin
        check_val("hold_valid", {31'd0, out_valid}, 32'd1);
        check_val("hold_data", out_data, pd);
        check_val("hold_addr", {28'd0, out_addr}, {28'd0, pa});
      end
      if (out_valid && !out_ready) check_val("bp_in_ready", {31'd0, in_ready}, 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_out", exp_q.size(), 32'd1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_val("out_data", out_data, e.d);
          check_val("out_addr", {28'd0, out_addr}, e.a);
        end
        last_out_cyc = cyc;
        last_out_adr = out_addr;
      end
      if (frame_done) begin
        done_cnt++;
        check_val("done_delay", cyc - last_out_cyc, 32'd1);
        check_val("done_last_addr", last_out_adr, PW * PH - 1);
      end
      mon_ok = 1'b1;
    end else begin
      mon_ok = 1'b0;
    end
    pv   = out_valid;
    pr_q = out_ready;
    pd   = out_data;
    pa   = out_addr;
  end

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_in_ready"},   {31'd0, in_ready},   32'd0);
    check_val({tag, "_out_valid"},  {31'd0, out_valid},  32'd0);
    check_val({tag, "_out_data"},   out_data,            32'd0);
    check_val({tag, "_out_addr"},   {28'd0, out_addr},   32'd0);
    check_val({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
  endtask

  // vmode: 0 always valid, 1 toggling, 2 random. rmode: 0 ready, 1 five-cycle stall, 2 random.
  task automatic run_frame(input int vmode, input int rmode, input int abort_at, input bit poke_start);
    int idx   = 0;
    int guard = 0;
    int bp_left = 5;
    int done0;
    bit tog = 1'b1;
    bit poked = 1'b0;
    load_model();
    done0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_val("ready_after_start", {31'd0, in_ready}, 32'd1);
    while (idx < W * H && guard < 2000) begin
      if (abort_at > 0 && idx == abort_at) begin
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("abort");
        exp_q.delete();
        rst = 1'b1;
        return;
      end
      case (vmode)
        0:       in_valid = 1'b1;
        1:       in_valid = tog;
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      tog = ~tog;
      in_data = img[idx / W][idx % W];
      if (rmode == 1) begin
        if (out_valid && bp_left > 0) begin
          out_ready = 1'b0;
          bp_left--;
        end else begin
          out_ready = 1'b1;
        end
      end else if (rmode == 2) begin
        out_ready = 1'($urandom_range(0, 1));
      end else begin
        out_ready = 1'b1;
      end
      start = (poke_start && !poked && idx == 10);
      if (start) poked = 1'b1;
      @(negedge clk); #1;
      if (in_valid && in_ready) idx++;
      guard++;
      @(posedge clk); #1;
      start = 1'b0;
    end
    if (vmode == 0 && rmode == 0) check_val("throughput_cycles", guard, W * H);
    if (rmode == 1) check_val("bp_stall_used", bp_left, 32'd0);
    guard = 0;
    while (done_cnt == done0 && guard < 200) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      out_ready = (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk); #1;
      guard++;
      if (done_cnt != done0) break;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check_val("frame_done_count", done_cnt - done0, 32'd1);
    check_val("all_outputs_seen", exp_q.size(), 32'd0);
    check_val("ready_low_in_done", {31'd0, in_ready}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("idle");

    fill_ramp();   run_frame(0, 0, 0, 1'b0);
    fill_signed(); run_frame(0, 0, 0, 1'b0);
    fill_ramp();   run_frame(0, 1, 0, 1'b0);
    fill_ramp();   run_frame(1, 0, 0, 1'b1);
    fill_ramp();   run_frame(0, 0, 20, 1'b0);
    fill_ramp();   run_frame(0, 0, 0, 1'b0);
    fill_ramp();   run_frame(0, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      fill_random();
      run_frame(2, 2, 0, 1'b1);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/max_pool_unit.md
# max_pool_unit

2x2, stride-2 max-pooling stage downstream of the convolution engine. It consumes the engine's 6x6 ReLU feature map as a raster-order stream over a valid/ready handshake and emits the 3x3 pooled map, also in raster order. Each output carries its write address. The block holds one row of partial maxima and streams continuously; it never stores a whole frame.

## Interface
Parameters:
- IN_WIDTH, 6, feature-map columns; even, at least 2.
- IN_HEIGHT, 6, feature-map rows; even, at least 2.
- DATA_W, 32, sample width, two's-complement signed.
- ADDR_W, 4, width of out_addr; must satisfy 2^ADDR_W ≥ (IN_WIDTH/2)*(IN_HEIGHT/2).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; one clock; reset is synchronous and active-low.
- start  in  1  one-cycle pulse that arms the block for one frame; sampled only in IDLE.
- in_valid  in  1  in_data is valid this cycle.
- in_data  in  DATA_W  signed feature-map sample, raster order.
- in_ready  out  1  block accepts in_data this cycle.
- out_valid  out  1  out_data and out_addr are valid.
- out_data  out  DATA_W  signed pooled maximum.
- out_addr  out  ADDR_W  pooled index: prow*(IN_WIDTH/2)+pcol.
- out_ready  in  1  consumer accepts the output.
- frame_done  out  1  one-cycle pulse after the final output handshake.

## Operation
- Handshakes: an input transfer occurs on a clk edge with in_valid&in_ready. An output transfer occurs on a clk edge with out_valid&out_ready.
- States:
  - IDLE: in_ready=0. start=1 → RUN, with row, col and out_addr cleared.
  - RUN: in_ready = ~out_valid | out_ready.
  - DRAIN: the last pooled value is pending. in_ready=0. When the output handshake completes → DONE.
  - DONE: frame_done=1 for this single cycle → IDLE.
- Counters: row (0..IN_HEIGHT-1) and col (0..IN_WIDTH-1) advance on every input transfer. col wraps to 0 and increments row.
- Internal registers:
  - tmp: one DATA_W register.
  - pmax[0..IN_WIDTH/2-1]: partial-maxima line buffer.
- Per accepted sample x at (row, col); k = col>>1:
  - even row, even col: tmp ← x.
  - even row, odd col: pmax[k] ← max(tmp, x).
  - odd row, even col: tmp ← max(pmax[k], x).
  - odd row, odd col: out_data ← max(tmp, x); out_valid ← 1.
- All comparisons are signed. On equal values either operand may be selected; the result is identical. No width growth occurs and nothing saturates.
- out_addr increments after each output transfer.
- The final sample (row=IN_HEIGHT-1, col=IN_WIDTH-1) loads the output and moves RUN → DRAIN.
- out_valid stays high, and out_data/out_addr stay stable, until the output transfer completes.
- An output transfer and a new input transfer may occur in the same cycle. A new output may load in the same cycle the previous one drains.
- start outside IDLE is ignored. in_valid in IDLE/DRAIN/DONE is not accepted and has no effect.
- After DONE, all counters are zero. The next start begins a fresh frame. pmax is not cleared; it is fully overwritten before it is read.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, out_addr=0, frame_done=0, state=IDLE, row=col=0, tmp=0.
- Reset asserted mid-frame aborts the frame at the next edge and returns all outputs to their reset values. Any partial output is discarded.
- start seen in IDLE at edge t: in_ready=1 from cycle t+1.
- Latency: out_valid rises the cycle after the odd-row, odd-col sample is accepted.
- Throughput: with out_ready held high, one sample is accepted every cycle; a full 6x6 frame takes 36 input cycles.
- Backpressure: while out_valid=1 and out_ready=0, in_ready=0. The block therefore never holds more than one pending output.
- frame_done pulses one cycle after the final output transfer. in_ready stays 0 until the next start.

## Test plan
- Ramp frame: in_data = r*6+c, out_ready=1, in_valid=1 → outputs 7, 9, 11, 19, 21, 23, 31, 33, 35 at addresses 0–8. frame_done pulses once, 1 cycle after the address-8 transfer.
- Signed data: all samples −5, except −1 at (0,1) and −7 at (5,5) → out_data −1 at address 0 and −5 at addresses 1–8.
- Backpressure: ramp frame, out_ready=0 for 5 cycles after the first out_valid → out_data=7/out_addr=0 held, in_ready=0 throughout. After release, the full sequence matches the ramp case with no sample lost or duplicated.
- Input bubbles: in_valid toggles 1,0,1,0… → same nine outputs as the ramp case; counters advance only on transfers.
- Reset mid-frame: rst=0 after 20 samples → next cycle all outputs at reset values and state IDLE. A new start plus ramp frame produces the correct nine outputs.
- Control: start pulsed during RUN is ignored. Back-to-back frames (start on the cycle after DONE) produce two identical ramp output sets, with addresses restarting at 0.
